// File: rtl/stopwatch_ctrl.sv
// Stopwatch front end: debounces the three push-buttons, divides clk down to
// the counter tick, and runs the user-mode FSM that drives the counter requests.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_STOPPED | counter halted; reset button clears the count
// ST_RUNNING | counter advancing; display shows live time
// ST_LAP     | counter advancing; display frozen on the lap snapshot
module stopwatch_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TICK_DIV        = 100000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_start_stop_raw,
  input  logic        btn_lap_raw,
  input  logic        btn_reset_raw,
  input  logic [15:0] time_data,
  output logic        tick,
  output logic        sw_start_stop,
  output logic        sw_reset,
  output logic [15:0] disp_data,
  output logic        running,
  output logic        lap_active
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned DIV_W = $clog2(TICK_DIV + 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  localparam int BTN_SS  = 0;
  localparam int BTN_LAP = 1;
  localparam int BTN_RST = 2;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_LAP     = 2'd2
  } state_t;

  state_t           state;
  logic [2:0]       btn_raw;
  logic [2:0]       btn_meta;
  logic [2:0]       btn_sync;
  logic [2:0]       btn_deb;
  logic [2:0]       btn_deb_q;
  logic [2:0]       btn_evt;
  logic [DB_W-1:0]  db_cnt [3];
  logic [DIV_W-1:0] div_cnt;
  logic [15:0]      lap_reg;
  logic             pending;
  logic             ev_reset;
  logic             ev_ss;
  logic             ev_lap;

  assign btn_raw = {btn_reset_raw, btn_lap_raw, btn_start_stop_raw};

  // The debounced level only moves after DEBOUNCE_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta  <= '0;
      btn_sync  <= '0;
      btn_deb   <= '0;
      btn_deb_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      btn_meta  <= btn_raw;
      btn_sync  <= btn_meta;
      btn_deb_q <= btn_deb;
      for (int i = 0; i < 3; i++) begin
        if (btn_sync[i] == btn_deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn_deb[i] <= ~btn_deb[i];
          db_cnt[i]  <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign btn_evt = btn_deb & ~btn_deb_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  // A counter request in flight blocks further start/stop and reset so the
  // counter never sees two requests within one tick period.
  assign pending  = sw_start_stop | sw_reset;
  assign ev_reset = btn_evt[BTN_RST] & ~pending;
  assign ev_ss    = btn_evt[BTN_SS] & ~pending;
  assign ev_lap   = btn_evt[BTN_LAP];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_STOPPED;
      sw_start_stop <= 1'b0;
      sw_reset      <= 1'b0;
      lap_reg       <= '0;
      running       <= 1'b0;
      lap_active    <= 1'b0;
    end else begin
      if (tick) begin
        sw_start_stop <= 1'b0;
        sw_reset      <= 1'b0;
      end
      case (state)
        ST_STOPPED: begin
          if (ev_reset) begin
            sw_reset <= 1'b1;
            lap_reg  <= '0;
          end else if (ev_ss) begin
            state         <= ST_RUNNING;
            sw_start_stop <= 1'b1;
            running       <= 1'b1;
          end
        end
        ST_RUNNING: begin
          // Reset wins arbitration even though it has no effect here.
          if (!ev_reset) begin
            if (ev_ss) begin
              state         <= ST_STOPPED;
              sw_start_stop <= 1'b1;
              running       <= 1'b0;
            end else if (ev_lap) begin
              state      <= ST_LAP;
              lap_reg    <= time_data;
              lap_active <= 1'b1;
            end
          end
        end
        ST_LAP: begin
          if (!ev_reset) begin
            if (ev_ss) begin
              state         <= ST_STOPPED;
              sw_start_stop <= 1'b1;
              running       <= 1'b0;
              lap_active    <= 1'b0;
            end else if (ev_lap) begin
              state      <= ST_RUNNING;
              lap_active <= 1'b0;
            end
          end
        end
        default: begin
          state      <= ST_STOPPED;
          running    <= 1'b0;
          lap_active <= 1'b0;
        end
      endcase
    end
  end

  assign disp_data = lap_active ? lap_reg : time_data;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed table, hand-timed corner sequences and
// random button traffic, all checked each cycle against a behavioural model.
module tb_stopwatch_ctrl;

  localparam int DEB = 4;
  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        b_ss = 1'b0;
  logic        b_lap = 1'b0;
  logic        b_rst = 1'b0;
  logic [15:0] td = 16'h0000;
  logic        tick;
  logic        sw_ss;
  logic        sw_rst;
  logic [15:0] disp;
  logic        running;
  logic        lap_active;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(DEB), .TICK_DIV(DIV)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .btn_start_stop_raw (b_ss),
    .btn_lap_raw        (b_lap),
    .btn_reset_raw      (b_rst),
    .time_data          (td),
    .tick               (tick),
    .sw_start_stop      (sw_ss),
    .sw_reset           (sw_rst),
    .disp_data          (disp),
    .running            (running),
    .lap_active         (lap_active)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: mode 0 stopped, 1 running, 2 lap.
  int          div_m;
  bit [2:0]    deb_m;
  bit [2:0]    evt_m;
  logic [15:0] hist_m [3];
  int          mode_m;
  bit          req_ss_m;
  bit          req_rst_m;
  logic [15:0] lap_m;

  typedef struct {
    int          btn;
    logic [15:0] tdv;
    logic        exp_run;
    logic        exp_lap;
    logic [15:0] exp_disp;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    div_m = 0;
    deb_m = '0;
    evt_m = '0;
    for (int i = 0; i < 3; i++) hist_m[i] = '0;
    mode_m = 0;
    req_ss_m = 1'b0;
    req_rst_m = 1'b0;
    lap_m = '0;
  endfunction

  // Advance the model across one rising edge, using pre-edge inputs.
  function automatic void model_edge();
    bit [2:0] raw;
    bit pend, e_rst, e_ss, e_lap, all_diff;
    raw = {b_rst, b_lap, b_ss};
    pend = req_ss_m || req_rst_m;
    e_rst = evt_m[2] && !pend;
    e_ss = evt_m[0] && !pend;
    e_lap = evt_m[1];
    if (div_m == DIV - 1) begin
      req_ss_m = 1'b0;
      req_rst_m = 1'b0;
    end
    if (e_rst) begin
      if (mode_m == 0) begin
        req_rst_m = 1'b1;
        lap_m = '0;
      end
    end else if (e_ss) begin
      req_ss_m = 1'b1;
      mode_m = (mode_m == 0) ? 1 : 0;
    end else if (e_lap) begin
      if (mode_m == 1) begin
        mode_m = 2;
        lap_m = td;
      end else if (mode_m == 2) begin
        mode_m = 1;
      end
    end
    div_m = (div_m + 1) % DIV;
    // Debounced level flips once the last DEB synchronised samples
    // (raw delayed by two flops) all disagree with it.
    for (int i = 0; i < 3; i++) begin
      hist_m[i] = {hist_m[i][14:0], raw[i]};
      all_diff = 1'b1;
      for (int k = 2; k <= DEB + 1; k++)
        if (hist_m[i][k] == deb_m[i]) all_diff = 1'b0;
      evt_m[i] = 1'b0;
      if (all_diff) begin
        deb_m[i] = ~deb_m[i];
        evt_m[i] = deb_m[i];
      end
    end
  endfunction

  task automatic check_outputs();
    chk("tick", 32'(tick), 32'(div_m == DIV - 1));
    chk("sw_start_stop", 32'(sw_ss), 32'(req_ss_m));
    chk("sw_reset", 32'(sw_rst), 32'(req_rst_m));
    chk("running", 32'(running), 32'(mode_m != 0));
    chk("lap_active", 32'(lap_active), 32'(mode_m == 2));
    chk("disp_data", 32'(disp), 32'((mode_m == 2) ? lap_m : td));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    b_ss = 1'b0;
    b_lap = 1'b0;
    b_rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic align(input int target);
    int guard;
    guard = 0;
    while (div_m != target && guard < 2 * DIV) begin
      step();
      guard++;
    end
    if (div_m != target) begin
      n_chk++;
      n_fail++;
      $display("FAIL align: divider phase %0d expected %0d", div_m, target);
    end
  endtask

  task automatic set_btn(input int btn, input logic v);
    case (btn)
      0: b_ss = v;
      1: b_lap = v;
      default: b_rst = v;
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int run_left [3];
    logic [2:0] rnd_raw;

    tbl[0]  = '{0, 16'h0100, 1'b1, 1'b0, 16'h0100};
    tbl[1]  = '{1, 16'h0123, 1'b1, 1'b1, 16'h0123};
    tbl[2]  = '{2, 16'h0125, 1'b1, 1'b1, 16'h0123};
    tbl[3]  = '{1, 16'h0126, 1'b1, 1'b0, 16'h0126};
    tbl[4]  = '{2, 16'h0200, 1'b1, 1'b0, 16'h0200};
    tbl[5]  = '{0, 16'h0300, 1'b0, 1'b0, 16'h0300};
    tbl[6]  = '{1, 16'h0310, 1'b0, 1'b0, 16'h0310};
    tbl[7]  = '{0, 16'h0320, 1'b1, 1'b0, 16'h0320};
    tbl[8]  = '{1, 16'h0333, 1'b1, 1'b1, 16'h0333};
    tbl[9]  = '{0, 16'h0400, 1'b0, 1'b0, 16'h0400};
    tbl[10] = '{2, 16'h0500, 1'b0, 1'b0, 16'h0500};
    tbl[11] = '{0, 16'h0600, 1'b1, 1'b0, 16'h0600};
    tbl[12] = '{0, 16'h0700, 1'b0, 1'b0, 16'h0700};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tick", 32'(tick), 32'(0));
    chk("reset_running", 32'(running), 32'(0));
    chk("reset_disp", 32'(disp), 32'(td));
    reset_n = 1'b1;

    // Tick period after reset release.
    for (int n = 1; n <= 35; n++) begin
      step();
      chk("tick_period", 32'(tick), 32'(n == 9 || n == 19 || n == 29));
    end

    // Short glitch is filtered, clean press lands seven edges later.
    b_ss = 1'b1;
    step();
    step();
    b_ss = 1'b0;
    repeat (6) step();
    chk("glitch_running", 32'(running), 32'(0));
    b_ss = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 6) begin
        chk("pre_press_running", 32'(running), 32'(0));
        chk("pre_press_req", 32'(sw_ss), 32'(0));
      end
    end
    chk("press_running", 32'(running), 32'(1));
    chk("press_req", 32'(sw_ss), 32'(1));
    align(DIV - 1);
    chk("req_held_in_tick", 32'(sw_ss), 32'(1));
    chk("ack_tick", 32'(tick), 32'(1));
    step();
    chk("req_cleared", 32'(sw_ss), 32'(0));
    b_ss = 1'b0;
    repeat (10) step();

    // Directed button table.
    do_reset();
    for (int v = 0; v < 13; v++) begin
      td = tbl[v].tdv;
      set_btn(tbl[v].btn, 1'b1);
      repeat (10) step();
      set_btn(tbl[v].btn, 1'b0);
      repeat (10) step();
      chk($sformatf("tbl%0d_running", v), 32'(running), 32'(tbl[v].exp_run));
      chk($sformatf("tbl%0d_lap", v), 32'(lap_active), 32'(tbl[v].exp_lap));
      chk($sformatf("tbl%0d_disp", v), 32'(disp), 32'(tbl[v].exp_disp));
    end

    // Start and reset land together while stopped; a second start during
    // the pending reset is dropped. Event cycle is placed on a tick.
    align(3);
    b_ss = 1'b1;
    b_rst = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 4) b_ss = 1'b0;
      if (k == 8) b_ss = 1'b1;
      if (k == 7) begin
        chk("coinc_sw_reset", 32'(sw_rst), 32'(1));
        chk("coinc_sw_ss", 32'(sw_ss), 32'(0));
        chk("coinc_running", 32'(running), 32'(0));
      end
      if (k == 15) begin
        chk("pend_drop_running", 32'(running), 32'(0));
        chk("pend_drop_sw_ss", 32'(sw_ss), 32'(0));
        chk("pend_sw_reset", 32'(sw_rst), 32'(1));
      end
      if (k == 16) chk("rst_req_in_tick", 32'(sw_rst), 32'(1));
      if (k == 17) chk("rst_req_cleared", 32'(sw_rst), 32'(0));
    end
    b_ss = 1'b0;
    b_rst = 1'b0;
    repeat (10) step();

    // Enter LAP while the start request is still pending, then pull reset.
    td = 16'h0777;
    align(3);
    b_ss = 1'b1;
    step();
    step();
    b_lap = 1'b1;
    for (int k = 3; k <= 9; k++) step();
    chk("lap_pend_lap", 32'(lap_active), 32'(1));
    chk("lap_pend_sw_ss", 32'(sw_ss), 32'(1));
    chk("lap_pend_disp", 32'(disp), 32'(16'h0777));
    #2;
    td = 16'h0888;
    reset_n = 1'b0;
    b_ss = 1'b0;
    b_lap = 1'b0;
    #1;
    chk("async_tick", 32'(tick), 32'(0));
    chk("async_sw_ss", 32'(sw_ss), 32'(0));
    chk("async_sw_reset", 32'(sw_rst), 32'(0));
    chk("async_running", 32'(running), 32'(0));
    chk("async_lap", 32'(lap_active), 32'(0));
    chk("async_disp", 32'(disp), 32'(16'h0888));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Random button traffic: mixes glitches, clean presses and overlaps.
    rnd_raw = '0;
    for (int i = 0; i < 3; i++) run_left[i] = $urandom_range(1, 14);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (run_left[i] == 0) begin
          rnd_raw[i] = ~rnd_raw[i];
          run_left[i] = $urandom_range(1, 14);
        end
        run_left[i]--;
      end
      b_ss = rnd_raw[0];
      b_lap = rnd_raw[1];
      b_rst = rnd_raw[2];
      td = 16'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
